// File: rtl/nes_joypad_pkg.sv
// Shared definitions for the NES joypad path: button bit positions and
// the constant values used by the serializer, the HID decoder and the OSD.
package nes_joypad_pkg;

   // Bit positions inside the 8-bit button vector {R,L,D,U,Start,Select,B,A}.
   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

   // Value of the shift register and the effective vector out of reset.
   localparam logic [7:0] BTN_RESET_VAL = 8'h00;

   // Bit shifted in from the top, so reads past the eighth return 1.
   localparam logic SHIFT_FILL_BIT = 1'b1;

endpackage : nes_joypad_pkg

// File: rtl/nes_autofire_gen.sv
// Autofire phase generator: a free-running counter of HALF cycles whose
// wrap toggles the phase. Phase 1 lets a turbo button through, 0 blocks it.
module nes_autofire_gen #(
   parameter int c_clk_hz      = 6000000,
   parameter int c_autofire_hz = 10
) (
   input  logic i_clk,
   input  logic i_rstn,
   output logic o_phase
);

   localparam int c_half  = c_clk_hz / (2 * c_autofire_hz);
   // A one-cycle half-period still needs a one-bit counter.
   localparam int c_cnt_w = (c_half > 1) ? $clog2(c_half) : 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_half - 1);

   if (c_half < 1) begin : g_bad_half
      $error("nes_autofire_gen: c_clk_hz/(2*c_autofire_hz) must be at least 1");
   end

   logic [c_cnt_w-1:0] cnt_d, cnt_q;
   logic               phase_d, phase_q;

   // Next counter value and phase: toggle the phase on every wrap.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      cnt_d   = cnt_q + c_cnt_w'(1);
      phase_d = phase_q;
      if (cnt_q == c_last) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end
   end

   // Counter and phase registers; phase starts at 1 so turbo buttons pass first.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         cnt_q   <= '0;
         phase_q <= 1'b1;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together.
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign o_phase = phase_q;

endmodule : nes_autofire_gen

// File: rtl/nes_joypad_serializer.sv
// NES controller emulation: registers the effective button vector (autofire
// and opposite-direction masking applied) and serves it through the
// strobe / serial-read protocol of a 4021-style shift register.
module nes_joypad_serializer
   import nes_joypad_pkg::*;
#(
   parameter int c_clk_hz        = 6000000,
   parameter int c_autofire_hz   = 10,
   parameter int c_mask_opposite = 1
) (
   input  logic       i_clk,
   input  logic       i_rstn,
   input  logic [7:0] i_btn,
   input  logic [1:0] i_turbo,
   input  logic       i_strobe,
   input  logic       i_read,
   output logic       o_data,
   output logic [7:0] o_btn_eff
);

   logic       phase;
   logic [7:0] btn_eff_d, btn_eff_q;
   logic [7:0] shift_d, shift_q;

   nes_autofire_gen #(
      .c_clk_hz      (c_clk_hz),
      .c_autofire_hz (c_autofire_hz)
   ) u_autofire (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .o_phase (phase)
   );

   // Effective vector: gate turbo buttons with the phase, then cancel opposite directions.
   always_comb begin
      btn_eff_d = i_btn;
      if (i_turbo[0]) btn_eff_d[BTN_A] = i_btn[BTN_A] & phase;
      if (i_turbo[1]) btn_eff_d[BTN_B] = i_btn[BTN_B] & phase;
      if (c_mask_opposite != 0) begin
         if (btn_eff_d[BTN_UP] && btn_eff_d[BTN_DOWN]) begin
            btn_eff_d[BTN_UP]   = 1'b0;
            btn_eff_d[BTN_DOWN] = 1'b0;
         end
         if (btn_eff_d[BTN_LEFT] && btn_eff_d[BTN_RIGHT]) begin
            btn_eff_d[BTN_LEFT]  = 1'b0;
            btn_eff_d[BTN_RIGHT] = 1'b0;
         end
      end
   end

   // Shift register: strobe reloads every cycle (and beats a read), a read shifts in the fill bit.
   always_comb begin
      shift_d = shift_q;
      if (i_strobe) begin
         shift_d = btn_eff_q;
      end else if (i_read) begin
         shift_d = {SHIFT_FILL_BIT, shift_q[7:1]};
      end
   end

   // Effective-vector and shift registers.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         btn_eff_q <= BTN_RESET_VAL;
         shift_q   <= BTN_RESET_VAL;
      end else begin
         btn_eff_q <= btn_eff_d;
         shift_q   <= shift_d;
      end
   end

   // The CPU samples the current bit during its read cycle; the shift lands on the next edge.
   assign o_data    = shift_q[0];
   assign o_btn_eff = btn_eff_q;

endmodule : nes_joypad_serializer
